seq_bit_serializer: RTL and testbench
=====================================

// Module: seq_bit_serializer
// PURPOSE
//  Upstream feed for the serial 1010 pattern detector.
//  Accepts parallel words over a valid/ready handshake and shifts each word out one bit per clock on d_out.
//  Inserts a configurable idle gap between words, holding d_out at a fixed idle level.
//  The idle level keeps the detector free of spurious patterns.
// PARAMETERS
//  WIDTH       8   bits per word (>=2)
//  GAP_CYCLES  0   idle cycles inserted after each word (0..255)
//  IDLE_BIT    0   level driven on d_out when not shifting
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  data_in     in   WIDTH  parallel word to serialize
//  data_valid  in   1      data_in valid
//  data_ready  out  1      block can accept a word
//  d_out       out  1      serial bit stream (to detector d_in)
//  bit_valid   out  1      d_out carries a payload bit this cycle
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n low): state=IDLE, shift_reg=0, bit_cnt=0, gap_cnt=0.
//    Outputs: d_out=IDLE_BIT, bit_valid=0, busy=0.
//    No transfer is accepted while rst_n is low.
//  - data_ready = (state==IDLE), combinational. Transfer occurs when data_valid && data_ready at a rising edge.
//  - FSM IDLE->SHIFT: on transfer, load shift_reg=data_in and set bit_cnt=0.
//    d_out and bit_valid are registered: the first bit appears the cycle after the transfer (latency 1).
//  - SHIFT: each cycle, d_out = next bit (MSB first) and bit_valid=1, for exactly WIDTH consecutive cycles.
//    After bit WIDTH-1: if GAP_CYCLES>0, go to GAP; otherwise go to IDLE.
//  - GAP: d_out=IDLE_BIT, bit_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
//  - IDLE: d_out=IDLE_BIT, bit_valid=0.
//  - Throughput: one word per WIDTH+GAP_CYCLES+1 cycles (the IDLE cycle carries the handshake).
//  - data_in and data_valid are ignored outside IDLE. data_in is captured only at transfer;
//    changes during SHIFT do not affect output.
//  - Counters: bit_cnt is $clog2(WIDTH) bits and gap_cnt is 8 bits. Neither wraps past its terminal value.
//  - Reset mid-word: the word is abandoned immediately, outputs go to reset values, and no partial resume.
//  - Holding data_valid high continuously produces back-to-back words separated by GAP_CYCLES+1 idle-level cycles.
// CONFIGURATION
//  - Macro SER_LSB_FIRST_EN:
//    - Defined: bits are shifted LSB first (data_in[0] first).
//    - Undefined (default): MSB first (data_in[WIDTH-1] first).
//    - Timing, handshake and gap behaviour are identical in both builds.
// TESTING
//  1. Reset: hold rst_n=0 and toggle data_valid.
//     -> d_out=IDLE_BIT, bit_valid=0, busy=0; no word shifted after release without a new transfer.
//  2. WIDTH=8, GAP=0, send 8'hA5 (MSB first).
//     -> d_out = 1,0,1,0,0,1,0,1 on cycles T+1..T+8 with bit_valid=1; data_ready=1 at T+9.
//  3. WIDTH=4, send 4'hA followed by 4'h0.
//     -> stream 1,0,1,0 then idle 0, then 0,0,0,0; bit_valid=0 on the idle cycle.
//  4. GAP_CYCLES=3, data_valid held high with 8'hFF.
//     -> 8 ones, then 4 cycles at IDLE_BIT (3 gap + 1 idle), then next 8 ones; data_ready high only in the idle cycle.
//  5. Assert rst_n=0 at bit 3 of 8'hC3.
//     -> d_out=IDLE_BIT and bit_valid=0 immediately (async); after release, data_ready=1 and no residual bits.
//  6. SER_LSB_FIRST_EN defined, send 8'h01.
//     -> d_out = 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial feed for the 1010 pattern detector
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   data_in    parallel word, captured on a valid/ready transfer
//   data_valid data_in is valid
//   data_ready high in IDLE, the only state that accepts a word
//   d_out      registered serial stream, IDLE_BIT between words
//   bit_valid  d_out carries a payload bit this cycle
//   busy       state is not IDLE
// Build option: define SER_LSB_FIRST_EN to shift data_in[0] first instead of data_in[WIDTH-1].
module seq_bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter bit IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             d_out,
    output logic             bit_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic d_out_q, d_out_d, bit_valid_q, bit_valid_d;
    // bit_cnt counts payload bits in transmission order; map it onto a word index
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] i);
`ifdef SER_LSB_FIRST_EN
        return w[i];
`else
        return w[BIT_LAST - i];
`endif
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            d_out_q     <= IDLE_BIT;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            d_out_q     <= d_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end
    // d_out/bit_valid are computed one cycle ahead so the first bit appears right after the transfer
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        d_out_d     = IDLE_BIT;
        bit_valid_d = 1'b0;
        case (state_q)
            IDLE: if (data_valid) begin
                state_d     = SHIFT;
                shift_d     = data_in;
                bit_cnt_d   = '0;
                d_out_d     = pick(data_in, '0);
                bit_valid_d = 1'b1;
            end
            SHIFT: if (bit_cnt_q == BIT_LAST) begin
                state_d   = GAP_CYCLES > 0 ? GAP : IDLE;
                gap_cnt_d = '0;
            end else begin
                bit_cnt_d   = bit_cnt_q + 1'b1;
                d_out_d     = pick(shift_q, bit_cnt_q + 1'b1);
                bit_valid_d = 1'b1;
            end
            GAP: if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                 else gap_cnt_d = gap_cnt_q + 8'd1;
            default: state_d = IDLE;
        endcase
    end
    assign data_ready = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign d_out      = d_out_q;
    assign bit_valid  = bit_valid_q;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed checks of the serializer in three configurations
module tb_seq_bit_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    logic [7:0] da, dc;
    logic [3:0] db;
    logic va, vb, vc, ra, rb, rc, oa, ob, oc, bva, bvb, bvc, ba, bb, bc;
    int errors = 0;
    int checks = 0;
    seq_bit_serializer #(.WIDTH(8), .GAP_CYCLES(0)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(da), .data_valid(va), .data_ready(ra),
        .d_out(oa), .bit_valid(bva), .busy(ba));
    seq_bit_serializer #(.WIDTH(4), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(db), .data_valid(vb), .data_ready(rb),
        .d_out(ob), .bit_valid(bvb), .busy(bb));
    seq_bit_serializer #(.WIDTH(8), .GAP_CYCLES(3)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(dc), .data_valid(vc), .data_ready(rc),
        .d_out(oc), .bit_valid(bvc), .busy(bc));
    function automatic logic eb(input logic [7:0] w, input int i, input int n);
`ifdef SER_LSB_FIRST_EN
        return w[i];
`else
        return w[n-1-i];
`endif
    endfunction
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic idle_all(input string tag);
        chk({tag, "_a"}, {5'd0, oa, bva, ba}, 8'h00);
        chk({tag, "_b"}, {5'd0, ob, bvb, bb}, 8'h00);
        chk({tag, "_c"}, {5'd0, oc, bvc, bc}, 8'h00);
    endtask
    initial begin
        va = 0; vb = 0; vc = 0; da = 0; db = 0; dc = 0;
        #1 rst_n = 1'b0;
        da = 8'hA5; db = 4'hA; dc = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            va = ~va; vb = ~vb; vc = ~vc;
            idle_all("in_reset");
        end
        @(negedge clk);
        va = 0; vb = 0; vc = 0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            idle_all("post_reset");
            chk("post_reset_ready", {5'd0, ra, rb, rc}, 8'h07);
        end
        va = 1; da = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            va = 0; da = 8'h00;
            chk("a5_bit", {7'd0, oa}, {7'd0, eb(8'hA5, i, 8)});
            chk("a5_valid_ready", {6'd0, bva, ra}, 8'h02);
        end
        @(negedge clk);
        chk("a5_end", {5'd0, ra, bva, oa}, 8'h04);
        vb = 1; db = 4'hA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            db = 4'h0;
            chk("w4_a_bit", {7'd0, ob}, {7'd0, eb(8'h0A, i, 4)});
            chk("w4_a_valid", {6'd0, bvb, rb}, 8'h02);
        end
        @(negedge clk);
        chk("w4_idle", {5'd0, rb, bvb, ob}, 8'h04);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vb = 0;
            chk("w4_zero_bit", {6'd0, bvb, ob}, 8'h02);
        end
        @(negedge clk);
        chk("w4_end", {5'd0, rb, bvb, ob}, 8'h04);
        vc = 1; dc = 8'hFF;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (w == 1) vc = 0;
                chk("gap_bit", {5'd0, oc, bvc, rc}, 8'h06);
            end
            for (int g = 0; g < 4; g++) begin
                @(negedge clk);
                chk("gap_idle", {4'd0, oc, bvc, rc, bc}, (g == 3) ? 8'h02 : 8'h01);
            end
        end
        @(negedge clk);
        chk("gap_end", {5'd0, oc, bvc, rc}, 8'h01);
        va = 1; da = 8'hC3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            va = 0;
            chk("c3_bit", {6'd0, oa, bva}, {6'd0, eb(8'hC3, i, 8), 1'b1});
        end
        rst_n = 1'b0;
        #1;
        idle_all("async_reset");
        @(negedge clk);
        va = 1;
        idle_all("reset_held");
        @(negedge clk);
        va = 0;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("no_resume", {5'd0, ra, bva, oa}, 8'h04);
        end
        va = 1; da = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            va = 0;
            chk("h01_bit", {6'd0, oa, bva}, {6'd0, eb(8'h01, i, 8), 1'b1});
        end
        @(negedge clk);
        chk("h01_end", {5'd0, ra, bva, oa}, 8'h04);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
